// File: rtl/spi_ram_ctrl.sv
// Command sequencer between the SPI slave's parallel side and a single-port synchronous RAM.
// Define SPI_RAM_AUTO_INC_EN to post-increment wr_addr/rd_addr after each write/read.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [9:0]           rx_data,
    input  logic [7:0]           mem_rdata,
    input  logic                 err_clr,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        TX       = 2'd3
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    if ((ADDR_SIZE < 1) || (ADDR_SIZE > 8) || (MEM_DEPTH != (1 << ADDR_SIZE))) begin : g_param_check
        $error("spi_ram_ctrl: ADDR_SIZE must be 1..8 and MEM_DEPTH must equal 2**ADDR_SIZE");
    end

    state_t               state, state_d;
    logic [ADDR_SIZE-1:0] wr_addr, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr, rd_addr_d;
    logic                 wr_vld, wr_vld_d;
    logic                 rd_vld, rd_vld_d;
    logic                 mem_we_d, mem_re_d;
    logic [ADDR_SIZE-1:0] mem_addr_d;
    logic [7:0]           mem_wdata_d;
    logic                 tx_valid_d;
    logic [7:0]           tx_data_d;
    logic                 busy_d;
    logic                 err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Every output is a register loaded from its *_d value, so strobes appear the cycle after the deciding edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            wr_vld    <= 1'b0;
            rd_vld    <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_addr   <= wr_addr_d;
            rd_addr   <= rd_addr_d;
            wr_vld    <= wr_vld_d;
            rd_vld    <= rd_vld_d;
            mem_we    <= mem_we_d;
            mem_re    <= mem_re_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            tx_valid  <= tx_valid_d;
            tx_data   <= tx_data_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        wr_addr_d   = wr_addr;
        rd_addr_d   = rd_addr;
        wr_vld_d    = wr_vld;
        rd_vld_d    = rd_vld;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data;
        // Clear first so that any drop below overrides a simultaneous err_clr.
        err_d       = err & ~err_clr;

        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    unique case (rx_data[9:8])
                        CMD_WR_ADDR: begin
                            wr_addr_d = rx_data[ADDR_SIZE-1:0];
                            wr_vld_d  = 1'b1;
                        end
                        CMD_WR_DATA: begin
                            if (wr_vld) begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = wr_addr;
                                mem_wdata_d = rx_data[7:0];
`ifdef SPI_RAM_AUTO_INC_EN
                                wr_addr_d   = wr_addr + ADDR_SIZE'(1);
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_RD_ADDR: begin
                            rd_addr_d = rx_data[ADDR_SIZE-1:0];
                            rd_vld_d  = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            if (rd_vld) begin
                                state_d    = RD_ISSUE;
                                mem_re_d   = 1'b1;
                                mem_addr_d = rd_addr;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                tx_data_d  = mem_rdata;
                tx_valid_d = 1'b1;
                state_d    = TX;
            end
            TX: begin
`ifdef SPI_RAM_AUTO_INC_EN
                rd_addr_d = rd_addr + ADDR_SIZE'(1);
`endif
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state != IDLE) && rx_valid) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: a frame-level reference model predicts RAM cycles,
// read returns, busy and err per cycle; a negedge monitor compares what the DUT presents.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = '0;
    logic [7:0] mem_rdata;
    logic       err_clr = 1'b0;
    logic       mem_we, mem_re, tx_valid, busy, err;
    logic [7:0] mem_addr, mem_wdata, tx_data;

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_rdata(mem_rdata), .err_clr(err_clr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .tx_valid(tx_valid),
        .tx_data(tx_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Synchronous RAM: reads return one cycle after mem_re, untouched cells hold init_val.
    logic [7:0] ram [256];
    bit         ram_written [256];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]         <= mem_wdata;
            ram_written[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= ram_written[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
    end

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    ev_t wq[$];
    ev_t rq[$];
    ev_t tq[$];
    bit  exp_err[int];
    bit  exp_busy[int];

    int  tests = 0;
    int  failed = 0;

    logic [7:0] ref_mem [256];
    int  m_wr_addr, m_rd_addr, rd_edge;
    bit  m_wr_vld, m_rd_vld, m_err;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        tests = tests + 1;
        if (actual !== required) begin
            failed = failed + 1;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, required);
        end
    endtask

    // Drives one cycle of inputs and advances the frame-level model for the edge that samples them.
    task automatic apply_stimulus(input bit v, input logic [9:0] f, input bit clr);
        int  e;
        bit  nerr;
        ev_t ev;
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = f;
        err_clr  = clr;
        e    = cyc + 1;
        nerr = clr ? 1'b0 : m_err;
        if (v) begin
            if (e > rd_edge && e <= rd_edge + 3) begin
                nerr = 1'b1;
            end else begin
                case (f[9:8])
                    2'b00: begin
                        m_wr_addr = int'(f[7:0]);
                        m_wr_vld  = 1'b1;
                    end
                    2'b01: begin
                        if (m_wr_vld) begin
                            ref_mem[m_wr_addr] = f[7:0];
                            ev.cyc = e; ev.addr = m_wr_addr; ev.data = int'(f[7:0]);
                            wq.push_back(ev);
`ifdef SPI_RAM_AUTO_INC_EN
                            m_wr_addr = (m_wr_addr + 1) % 256;
`endif
                        end else begin
                            nerr = 1'b1;
                        end
                    end
                    2'b10: begin
                        m_rd_addr = int'(f[7:0]);
                        m_rd_vld  = 1'b1;
                    end
                    default: begin
                        if (m_rd_vld) begin
                            rd_edge = e;
                            ev.cyc = e; ev.addr = m_rd_addr; ev.data = 0;
                            rq.push_back(ev);
                            ev.cyc = e + 2; ev.data = int'(ref_mem[m_rd_addr]);
                            tq.push_back(ev);
                            for (int i = 0; i < 3; i++) exp_busy[e + i] = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                            m_rd_addr = (m_rd_addr + 1) % 256;
`endif
                        end else begin
                            nerr = 1'b1;
                        end
                    end
                endcase
            end
        end
        m_err      = nerr;
        exp_err[e] = nerr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 10'h000, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        wq.delete(); rq.delete(); tq.delete(); exp_busy.delete();
        m_wr_addr = 0; m_rd_addr = 0; m_wr_vld = 1'b0; m_rd_vld = 1'b0; m_err = 1'b0;
        rd_edge = -100;
        exp_err[cyc] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp_err[cyc] = 1'b0;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a RAM cycle or a read return.
    logic [7:0] exp_tx_hold = '0;
    always @(negedge clk) begin
        ev_t ev;
        if (!rst_n) begin
            exp_tx_hold = '0;
            check_output("reset_outputs",
                         {mem_we, mem_re, tx_valid, busy, err, tx_data, mem_addr, mem_wdata}, '0);
        end else begin
            check_output("we_re_exclusive", 64'(mem_we & mem_re), 0);
            if (mem_we) begin
                if (wq.size() == 0) begin
                    check_output("write_unexpected", 64'(mem_we), 0);
                end else begin
                    ev = wq.pop_front();
                    check_output("write_cycle", cyc, ev.cyc);
                    check_output("write_addr", mem_addr, ev.addr);
                    check_output("write_data", mem_wdata, ev.data);
                end
            end
            if (mem_re) begin
                if (rq.size() == 0) begin
                    check_output("read_unexpected", 64'(mem_re), 0);
                end else begin
                    ev = rq.pop_front();
                    check_output("read_cycle", cyc, ev.cyc);
                    check_output("read_addr", mem_addr, ev.addr);
                end
            end
            if (tx_valid) begin
                if (tq.size() == 0) begin
                    check_output("tx_unexpected", 64'(tx_valid), 0);
                end else begin
                    ev = tq.pop_front();
                    check_output("tx_cycle", cyc, ev.cyc);
                    check_output("tx_data", tx_data, ev.data);
                    exp_tx_hold = 8'(ev.data);
                end
            end else begin
                check_output("tx_data_hold", tx_data, exp_tx_hold);
            end
            check_output("busy", 64'(busy), 64'(exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0));
            if (exp_err.exists(cyc)) check_output("err", 64'(err), 64'(exp_err[cyc]));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] p;
        int         r;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        #2 rst_n = 1'b0;
        do_reset(3);

        // Write address then data.
        apply_stimulus(1'b1, 10'h00A, 1'b0);
        apply_stimulus(1'b1, 10'h155, 1'b0);
        idle(3);
        // Read back the same cell.
        apply_stimulus(1'b1, 10'h20A, 1'b0);
        apply_stimulus(1'b1, 10'h300, 1'b0);
        idle(5);

        // Write data with no address after reset, then clear.
        do_reset(2);
        apply_stimulus(1'b1, 10'h1AA, 1'b0);
        idle(2);
        apply_stimulus(1'b0, 10'h000, 1'b1);
        idle(2);

        // Frame arriving mid-read is dropped; the read still completes.
        apply_stimulus(1'b1, 10'h005, 1'b0);
        apply_stimulus(1'b1, 10'h20A, 1'b0);
        apply_stimulus(1'b1, 10'h300, 1'b0);
        idle(1);
        apply_stimulus(1'b1, 10'h0FF, 1'b0);
        idle(4);
        apply_stimulus(1'b1, 10'h177, 1'b1);
        idle(3);

        // Reset while the read sits in RD_WAIT.
        apply_stimulus(1'b1, 10'h300, 1'b0);
        idle(1);
        do_reset(2);
        idle(4);
        apply_stimulus(1'b1, 10'h300, 1'b0);
        idle(3);
        apply_stimulus(1'b0, 10'h000, 1'b1);

        // Address wrap sequence.
        apply_stimulus(1'b1, 10'h0FF, 1'b0);
        apply_stimulus(1'b1, 10'h111, 1'b0);
        apply_stimulus(1'b1, 10'h122, 1'b0);
        apply_stimulus(1'b1, 10'h2FF, 1'b0);
        apply_stimulus(1'b1, 10'h300, 1'b0);
        idle(3);
        apply_stimulus(1'b1, 10'h300, 1'b0);
        idle(4);

        // Randomized traffic, addresses clustered near both ends of the map.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            p = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) p = p | 8'hF0;
            if (r < 4) begin
                apply_stimulus(1'b0, {2'($urandom_range(0, 3)), p}, ($urandom_range(0, 15) == 0));
            end else begin
                apply_stimulus(1'b1, {2'($urandom_range(0, 3)), p}, ($urandom_range(0, 15) == 0));
            end
        end
        idle(8);

        check_output("pending_writes", wq.size(), 0);
        check_output("pending_reads", rq.size(), 0);
        check_output("pending_tx", tq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
